// File: rtl/cbu_timer_ctrl_if.sv
// Bus between the timer controller, its requester and the cascaded counter slices.
// The master side drives the requests and returns the slice-chain count in QIN.
interface cbu_timer_ctrl_if #(
    parameter int SLICES = 2
);
    localparam int W = 8 * SLICES;

    logic         START;
    logic         STOP;
    logic         MODE;
    logic [W-1:0] LIMIT;
    logic [W-1:0] QIN;
    logic         CNT_CLR;
    logic         CNT_EN;
    logic         CNT_CAI;
    logic         BUSY;
    logic         EXPIRE;
    logic [7:0]   EXP_CNT;

    modport master (
        output START, STOP, MODE, LIMIT, QIN,
        input  CNT_CLR, CNT_EN, CNT_CAI, BUSY, EXPIRE, EXP_CNT
    );

    modport slave (
        input  START, STOP, MODE, LIMIT, QIN,
        output CNT_CLR, CNT_EN, CNT_CAI, BUSY, EXPIRE, EXP_CNT
    );
endinterface

// File: rtl/cbu_timer_ctrl.sv
// Sequencer turning a cascade of 8-bit counter slices into a one-shot or periodic timer.
// Clears the chain, enables it up to a latched limit, and reports expiries.
module cbu_timer_ctrl #(
    parameter int SLICES = 2
) (
    input  logic              CLK,
    input  logic              CDN,
    cbu_timer_ctrl_if.slave   bus
);
    localparam int W = 8 * SLICES;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        RUN   = 2'b10
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] limit_q, limit_d;
    logic         mode_q, mode_d;
    logic         clr_q, clr_d;
    logic         busy_q, busy_d;
    logic         expire_q, expire_d;
    logic [7:0]   exp_cnt_q, exp_cnt_d;
    logic         term;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Enable drops at the limit so the chain parks on it and never overruns.
    assign term        = (bus.QIN == limit_q);
    assign bus.CNT_EN  = (state_q == RUN) && !term;
    assign bus.CNT_CAI = bus.CNT_EN;

    assign bus.CNT_CLR = clr_q;
    assign bus.BUSY    = busy_q;
    assign bus.EXPIRE  = expire_q;
    assign bus.EXP_CNT = exp_cnt_q;

    always_comb begin
        state_d   = state_q;
        limit_d   = limit_q;
        mode_d    = mode_q;
        clr_d     = 1'b0;
        busy_d    = busy_q;
        expire_d  = 1'b0;
        exp_cnt_d = exp_cnt_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.START) begin
                    limit_d   = bus.LIMIT;
                    mode_d    = bus.MODE;
                    exp_cnt_d = 8'd0;
                    state_d   = CLEAR;
                    clr_d     = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            CLEAR: begin
                if (bus.STOP) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // An abort wins over a coincident terminal count.
                if (bus.STOP) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (term) begin
                    expire_d  = 1'b1;
                    exp_cnt_d = sat_inc(exp_cnt_q);
                    if (mode_q) begin
                        state_d = CLEAR;
                        clr_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CDN) begin
        if (!CDN) begin
            state_q   <= IDLE;
            limit_q   <= '0;
            mode_q    <= 1'b0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            expire_q  <= 1'b0;
            exp_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            limit_q   <= limit_d;
            mode_q    <= mode_d;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            expire_q  <= expire_d;
            exp_cnt_q <= exp_cnt_d;
        end
    end
endmodule

// File: tb/tb_cbu_timer_ctrl.sv
// Bench for cbu_timer_ctrl driving a two-slice counter chain; expectations come
// from a closed-form timing model indexed by clock edges since the accepted START.
module tb_cbu_timer_ctrl;
    logic CLK;
    logic CDN;
    int   checks;
    int   errors;

    cbu_timer_ctrl_if #(.SLICES(2)) ifc ();

    cbu_timer_ctrl #(.SLICES(2)) dut (
        .CLK (CLK),
        .CDN (CDN),
        .bus (ifc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Two chained 8-bit slices: async clear, enable, carry-in from CNT_CAI.
    logic [7:0] q0, q1;
    always_ff @(posedge CLK or posedge ifc.CNT_CLR) begin
        if (ifc.CNT_CLR) begin
            q0 <= 8'd0;
            q1 <= 8'd0;
        end else if (ifc.CNT_CAI) begin
            q0 <= q0 + 8'd1;
            if (q0 == 8'hFF) q1 <= q1 + 8'd1;
        end
    end
    assign ifc.QIN = {q1, q0};

    // Packing: {BUSY, CNT_CLR, CNT_EN, CNT_CAI, EXPIRE, EXP_CNT[7:0], QIN[15:0]}
    function automatic logic [28:0] model(input int k, input int L, input bit M);
        int         P;
        int         p;
        logic       b, c, e, x;
        logic [7:0] n;
        logic [15:0] q;
        P = L + 2;
        if (!M && k >= P) begin
            b = 1'b0; c = 1'b0; e = 1'b0;
            x = (k == P);
            n = 8'd1;
            q = L[15:0];
        end else begin
            p = k % P;
            b = 1'b1;
            c = (p == 0);
            e = (p >= 1) && (p <= L);
            x = (p == 0) && (k > 0);
            n = ((k / P) > 255) ? 8'd255 : 8'((k / P));
            q = (p == 0) ? 16'd0 : 16'((p - 1));
        end
        return {b, c, e, e, x, n, q};
    endfunction

    function automatic logic [28:0] observe();
        return {ifc.BUSY, ifc.CNT_CLR, ifc.CNT_EN, ifc.CNT_CAI, ifc.EXPIRE, ifc.EXP_CNT, ifc.QIN};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input int L, input bit M);
        ifc.LIMIT = L[15:0];
        ifc.MODE  = M;
        ifc.START = 1'b1;
        step();
        ifc.START = 1'b0;
    endtask

    task automatic test_reset();
        logic [28:0] got, expv;
        CDN = 1'b0;
        #3;
        checks++;
        got = observe();
        if (got[28:16] !== 13'd0) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", got[28:16], 13'd0);
        end
        #4 CDN = 1'b1;
        step();
        do_start(6, 1'b1);
        for (int k = 0; k <= 22; k++) begin
            got = observe(); expv = model(k, 6, 1'b1);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL reset_prerun k=%0d got=%h exp=%h", k, got, expv);
            end
            if (k < 22) step();
        end
        #2 CDN = 1'b0;
        #1;
        got = observe();
        checks++;
        if (got !== {13'd0, 16'd5}) begin
            errors++;
            $display("FAIL reset_midrun got=%h exp=%h", got, {13'd0, 16'd5});
        end
        #2 CDN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            got = observe();
            checks++;
            if (got !== {13'd0, 16'd5}) begin
                errors++;
                $display("FAIL reset_after k=%0d got=%h exp=%h", k, got, {13'd0, 16'd5});
            end
        end
    endtask

    task automatic test_oneshot();
        logic [28:0] got, expv;
        do_start(3, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            got = observe(); expv = model(k, 3, 1'b0);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL oneshot k=%0d got=%h exp=%h", k, got, expv);
            end
            step();
        end
    endtask

    task automatic test_periodic();
        logic [28:0] got, expv;
        int nexp, nclr;
        nexp = 0; nclr = 0;
        do_start(1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            got = observe(); expv = model(k, 1, 1'b1);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL periodic k=%0d got=%h exp=%h", k, got, expv);
            end
            nexp += int'(ifc.EXPIRE);
            nclr += int'(ifc.CNT_CLR);
            if (k < 19) step();
        end
        checks++;
        if (nexp != 6 || nclr != 7 || ifc.EXP_CNT !== 8'd6) begin
            errors++;
            $display("FAIL periodic_totals expiries=%0d clears=%0d exp_cnt=%0d exp=6/7/6", nexp, nclr, ifc.EXP_CNT);
        end
        ifc.STOP = 1'b1;
        step();
        ifc.STOP = 1'b0;
        checks++;
        if (ifc.BUSY !== 1'b0 || ifc.CNT_EN !== 1'b0) begin
            errors++;
            $display("FAIL periodic_stop busy=%b en=%b exp=0/0", ifc.BUSY, ifc.CNT_EN);
        end
    endtask

    task automatic test_collide();
        logic [28:0] got, expv;
        do_start(4, 1'b1);
        for (int k = 0; k <= 11; k++) begin
            got = observe(); expv = model(k, 4, 1'b1);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL collide_run k=%0d got=%h exp=%h", k, got, expv);
            end
            if (k < 11) step();
        end
        ifc.STOP = 1'b1;
        step();
        ifc.STOP = 1'b0;
        for (int k = 0; k < 3; k++) begin
            got = observe();
            checks++;
            if (got !== {5'd0, 8'd1, 16'd4}) begin
                errors++;
                $display("FAIL collide_stop k=%0d got=%h exp=%h", k, got, {5'd0, 8'd1, 16'd4});
            end
            step();
        end
    endtask

    task automatic test_bounds();
        logic [28:0] got, expv;
        do_start(0, 1'b0);
        for (int k = 0; k <= 4; k++) begin
            got = observe(); expv = model(k, 0, 1'b0);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL limit_zero k=%0d got=%h exp=%h", k, got, expv);
            end
            step();
        end
        do_start(65535, 1'b0);
        for (int k = 0; k <= 65540; k++) begin
            got = observe(); expv = model(k, 65535, 1'b0);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL limit_max k=%0d got=%h exp=%h", k, got, expv);
            end
            step();
        end
    endtask

    task automatic test_saturation();
        logic [28:0] got, expv;
        do_start(0, 1'b1);
        for (int k = 0; k <= 600; k++) begin
            got = observe(); expv = model(k, 0, 1'b1);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL saturation k=%0d got=%h exp=%h", k, got, expv);
            end
            if (k == 100) begin
                ifc.START = 1'b1; ifc.LIMIT = 16'h0010; ifc.MODE = 1'b0;
            end else if (k == 101) begin
                ifc.START = 1'b0;
            end
            if (k < 600) step();
        end
        ifc.STOP = 1'b1;
        step();
        ifc.STOP = 1'b0;
        got = observe();
        checks++;
        if (got !== {5'd0, 8'd255, 16'd0}) begin
            errors++;
            $display("FAIL saturation_stop got=%h exp=%h", got, {5'd0, 8'd255, 16'd0});
        end
        step();
        do_start(5, 1'b0);
        got = observe(); expv = model(0, 5, 1'b0);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL restart_clears got=%h exp=%h", got, expv);
        end
        for (int k = 1; k <= 8; k++) step();
    endtask

    task automatic test_random();
        logic [28:0] got, expv;
        int L, n;
        bit M;
        for (int it = 0; it < 12; it++) begin
            L = int'($urandom_range(0, 12));
            M = 1'($urandom_range(0, 1));
            n = int'($urandom_range(3, 40));
            do_start(L, M);
            for (int k = 0; k <= n; k++) begin
                got = observe(); expv = model(k, L, M);
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL random it=%0d L=%0d M=%0d k=%0d got=%h exp=%h", it, L, M, k, got, expv);
                end
                ifc.LIMIT = 16'($urandom());
                ifc.MODE  = 1'($urandom_range(0, 1));
                ifc.START = expv[28] ? 1'($urandom_range(0, 1)) : 1'b0;
                if (k < n) step();
            end
            ifc.START = 1'b0;
            ifc.STOP  = 1'b1;
            step();
            ifc.STOP  = 1'b0;
            got = observe();
            checks++;
            if (got[28:16] !== {5'd0, expv[23:16]}) begin
                errors++;
                $display("FAIL random_stop it=%0d got=%h exp=%h", it, got[28:16], {5'd0, expv[23:16]});
            end
            step();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ifc.START = 1'b0;
        ifc.STOP  = 1'b0;
        ifc.MODE  = 1'b0;
        ifc.LIMIT = '0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_collide();
        test_bounds();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
